// File: rtl/trap_pkg.sv
// Shared types and constants for the commit-stage trap sequencer.
package trap_pkg;

    localparam int XLEN_DFLT = 64;
    localparam int INT_BIT   = XLEN_DFLT - 1;

    localparam logic [1:0] RET_M = 2'b11;
    localparam logic [1:0] RET_S = 2'b01;
    localparam logic [1:0] RET_U = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        WFI   = 2'd2
    } state_t;

    // One-hot event select; EV_NONE means no valid head was offered.
    typedef enum logic [6:0] {
        EV_NONE  = 7'b0000000,
        EV_IRQ   = 7'b0000001,
        EV_EXC   = 7'b0000010,
        EV_EOUT  = 7'b0000100,
        EV_RET   = 7'b0001000,
        EV_FLUSH = 7'b0010000,
        EV_WFI   = 7'b0100000,
        EV_PLAIN = 7'b1000000
    } ev_t;

    function automatic logic ev_is_trap(input ev_t ev);
        return (ev == EV_IRQ) || (ev == EV_EXC) || (ev == EV_EOUT);
    endfunction

endpackage

// File: rtl/trap_sel.sv
// Fixed-priority event encoder for the ROB head: picks one event and forms cause/tval.
module trap_sel
    import trap_pkg::*;
#(
    parameter int XLEN      = XLEN_DFLT,
    parameter int ILL_CAUSE = 2
) (
    input  logic            cmt_vld,
    input  logic            cmt_exc,
    input  logic [XLEN-1:0] cmt_cause,
    input  logic [XLEN-1:0] cmt_tval,
    input  logic            cmt_ret_vld,
    input  logic            cmt_wfi,
    input  logic            csr_eout,
    input  logic            csr_flush,
    input  logic [6:0]      csr_intg,
    output ev_t             ev,
    output logic [XLEN-1:0] cause,
    output logic [XLEN-1:0] tval
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the if-chain infers a latch.
        ev    = EV_NONE;
        cause = '0;
        tval  = '0;
        if (cmt_vld) begin
            if (csr_intg[6]) begin
                ev    = EV_IRQ;
                cause = {1'b1, {(XLEN-7){1'b0}}, csr_intg[5:0]};
            end else if (cmt_exc) begin
                ev    = EV_EXC;
                cause = cmt_cause;
                tval  = cmt_tval;
            end else if (csr_eout) begin
                ev    = EV_EOUT;
                cause = XLEN'(ILL_CAUSE);
            end else if (cmt_ret_vld) begin
                ev = EV_RET;
            end else if (csr_flush) begin
                ev = EV_FLUSH;
            end else if (cmt_wfi) begin
                ev = EV_WFI;
            end else begin
                ev = EV_PLAIN;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Commit-stage trap sequencer: trap/xRET strobes to the CSR file, one-cycle flush+redirect, WFI halt.
// Optional statistics counters are built when TRAP_CTRL_STATS_EN is defined.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN      = XLEN_DFLT,
    parameter int ILL_CAUSE = 2,
    parameter int CNT_W     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmt_vld,
    input  logic [XLEN-1:0]  cmt_pc,
    input  logic             cmt_exc,
    input  logic [XLEN-1:0]  cmt_cause,
    input  logic [XLEN-1:0]  cmt_tval,
    input  logic [2:0]       cmt_ret,
    input  logic             cmt_wfi,
    output logic             cmt_ack,
    input  logic             csr_eout,
    input  logic             csr_flush,
    input  logic [6:0]       csr_intg,
    input  logic             csr_intl,
    input  logic [XLEN-1:0]  csr_tvec,
    input  logic [XLEN-1:0]  csr_mepc,
    input  logic [XLEN-1:0]  csr_sepc,
    output logic             csr_ein,
    output logic [XLEN-1:0]  csr_epc,
    output logic [XLEN-1:0]  csr_tval,
    output logic [XLEN-1:0]  csr_cause,
    output logic [2:0]       csr_ret,
    output logic             flush,
    output logic             redir_vld,
    output logic [XLEN-1:0]  redir_pc,
    output logic             halt,
    output logic [CNT_W-1:0] trap_cnt,
    output logic [CNT_W-1:0] irq_cnt
);

    state_t          r_state;
    logic            r_flush;
    logic            r_redir_vld;
    logic [XLEN-1:0] r_redir_pc;
    logic            r_halt;

    logic            w_sel_vld;
    ev_t             w_ev;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_tval;
    logic            w_trap;
    logic            w_redir;
    logic [XLEN-1:0] w_target;

    // Only a valid head seen in IDLE outside reset can produce an event.
    assign w_sel_vld = cmt_vld && (r_state == IDLE) && !rst;

    trap_sel #(
        .XLEN      (XLEN),
        .ILL_CAUSE (ILL_CAUSE)
    ) u_sel (
        .cmt_vld     (w_sel_vld),
        .cmt_exc     (cmt_exc),
        .cmt_cause   (cmt_cause),
        .cmt_tval    (cmt_tval),
        .cmt_ret_vld (cmt_ret[2]),
        .cmt_wfi     (cmt_wfi),
        .csr_eout    (csr_eout),
        .csr_flush   (csr_flush),
        .csr_intg    (csr_intg),
        .ev          (w_ev),
        .cause       (w_cause),
        .tval        (w_tval)
    );

    assign w_trap  = ev_is_trap(w_ev);
    assign w_redir = w_trap || (w_ev == EV_RET) || (w_ev == EV_FLUSH);

    assign csr_ein   = w_trap;
    assign csr_epc   = w_trap ? cmt_pc  : '0;
    assign csr_tval  = w_trap ? w_tval  : '0;
    assign csr_cause = w_trap ? w_cause : '0;
    assign csr_ret   = (w_ev == EV_RET) ? cmt_ret : 3'b000;
    assign cmt_ack   = (w_ev == EV_RET) || (w_ev == EV_FLUSH) ||
                       (w_ev == EV_WFI) || (w_ev == EV_PLAIN);

    // tvec is taken now, before the CSR file switches privilege on the trap strobe.
    always_comb begin
        w_target = '0;
        if (w_trap) begin
            w_target = csr_tvec;
        end else if (w_ev == EV_RET) begin
            case (cmt_ret[1:0])
                RET_M:   w_target = csr_mepc;
                RET_S:   w_target = csr_sepc;
                RET_U:   w_target = '0;
                default: w_target = '0;
            endcase
        end else if (w_ev == EV_FLUSH) begin
            w_target = cmt_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state     <= IDLE;
            r_flush     <= 1'b0;
            r_redir_vld <= 1'b0;
            r_redir_pc  <= '0;
            r_halt      <= 1'b0;
        end else begin
            r_flush     <= 1'b0;
            r_redir_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_redir) begin
                        r_state     <= REDIR;
                        r_flush     <= 1'b1;
                        r_redir_vld <= 1'b1;
                        r_redir_pc  <= w_target;
                    end else if (w_ev == EV_WFI) begin
                        r_state <= WFI;
                        r_halt  <= 1'b1;
                    end
                end
                REDIR: r_state <= IDLE;
                WFI: begin
                    if (csr_intl) begin
                        r_state <= IDLE;
                        r_halt  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_halt  <= 1'b0;
                end
            endcase
        end
    end

    assign flush     = r_flush;
    assign redir_vld = r_redir_vld;
    assign redir_pc  = r_redir_pc;
    assign halt      = r_halt;

`ifdef TRAP_CTRL_STATS_EN
    logic [CNT_W-1:0] r_trap_cnt;
    logic [CNT_W-1:0] r_irq_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap_cnt <= '0;
            r_irq_cnt  <= '0;
        end else begin
            if (w_trap)          r_trap_cnt <= r_trap_cnt + CNT_W'(1);
            if (w_ev == EV_IRQ)  r_irq_cnt  <= r_irq_cnt + CNT_W'(1);
        end
    end

    assign trap_cnt = r_trap_cnt;
    assign irq_cnt  = r_irq_cnt;
`else
    assign trap_cnt = '0;
    assign irq_cnt  = '0;
`endif

endmodule
